// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the x^26+x^6+x^2+x+1 LFSR stream: self-synchronises,
// then free-runs a reference register and flags and counts every mismatched bit.
module lfsr_seq_checker #(
  parameter int unsigned VERIFY_LEN = 8,
  parameter int unsigned ERR_LIMIT  = 4,
  parameter int unsigned WINDOW     = 256,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned VW = (VERIFY_LEN > 1) ? $clog2(VERIFY_LEN) : 1;
  localparam int unsigned WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned EW = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  state_t         state;
  logic [26:1]    sr;        // sr[k] holds the bit received k valid bits ago
  logic [4:0]     fill;
  logic [VW-1:0]  vcnt;
  logic [WW-1:0]  win_bits;
  logic [EW-1:0]  win_err;

  logic           pred;
  logic           miss;
  logic           wrap;
  logic [26:1]    sr_din;
  logic [26:1]    sr_ref;
  logic [EW-1:0]  win_err_inc;

  always_comb begin
    pred        = sr[20] ^ sr[24] ^ sr[25] ^ sr[26];
    miss        = din_bit ^ pred;
    sr_din      = {sr[25:1], din_bit};
    sr_ref      = {sr[25:1], pred};
    wrap        = (win_bits == WW'(WINDOW - 1));
    win_err_inc = win_err + EW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      sr       <= '0;
      fill     <= '0;
      vcnt     <= '0;
      win_bits <= '0;
      win_err  <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      err <= 1'b0;
      if (clr_cnt) err_cnt <= '0;

      if (en) begin
        case (state)
          SEARCH: begin
            sr <= sr_din;
            if (fill == 5'd25) begin
              // all-zero fill is the LFSR lockup state and would verify trivially
              fill <= '0;
              if (sr_din != '0) begin
                state <= VERIFY;
                vcnt  <= '0;
              end
            end else begin
              fill <= fill + 5'd1;
            end
          end

          VERIFY: begin
            sr <= sr_ref;
            if (miss) begin
              state <= SEARCH;
              fill  <= '0;
            end else if (vcnt == VW'(VERIFY_LEN - 1)) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              win_bits <= '0;
              win_err  <= '0;
            end else begin
              vcnt <= vcnt + VW'(1);
            end
          end

          LOCKED: begin
            // reference free-runs on its own prediction so a line error is counted once
            sr       <= sr_ref;
            win_bits <= wrap ? '0 : win_bits + WW'(1);
            if (wrap) win_err <= '0;
            if (miss) begin
              err <= 1'b1;
              if (clr_cnt)
                err_cnt <= CNT_W'(1);
              else if (err_cnt != '1)
                err_cnt <= err_cnt + CNT_W'(1);
              if (win_err_inc == EW'(ERR_LIMIT)) begin
                state  <= SEARCH;
                locked <= 1'b0;
                fill   <= '0;
              end else if (!wrap) begin
                win_err <= win_err_inc;
              end
            end
          end

          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
            fill   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed scoreboard bench for lfsr_seq_checker: a 16-bit counter instance plus a
// 2-bit counter instance driven in parallel so counter saturation is reachable.
module tb_lfsr_seq_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        din_bit = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, err;
  logic [15:0] err_cnt;
  logic        locked2, err2;
  logic [1:0]  err_cnt2;

  always #5 clk = ~clk;

  lfsr_seq_checker #(.VERIFY_LEN(8), .ERR_LIMIT(4), .WINDOW(256), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .din_bit(din_bit), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  lfsr_seq_checker #(.VERIFY_LEN(8), .ERR_LIMIT(4), .WINDOW(256), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .din_bit(din_bit), .clr_cnt(clr_cnt),
    .locked(locked2), .err(err2), .err_cnt(err_cnt2)
  );

  typedef struct {
    logic        xl;
    logic        xe;
    int unsigned xc;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // scripted expectations and reference generator
  logic [26:1] g;
  logic        e_locked = 1'b0;
  logic        acq = 1'b1;
  int unsigned e_cnt = 0;
  int unsigned vc = 0;
  int unsigned sl = 0;

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      logic [1:0] xc2;
      cur = sb.pop_front();
      xc2 = (cur.xc > 3) ? 2'd3 : 2'(cur.xc);
      n_cmp++;
      assert (locked === cur.xl) else begin
        n_bad++;
        $error("FAIL %s locked: observed %0b expected %0b", cur.tag, locked, cur.xl);
      end
      n_cmp++;
      assert (err === cur.xe) else begin
        n_bad++;
        $error("FAIL %s err: observed %0b expected %0b", cur.tag, err, cur.xe);
      end
      n_cmp++;
      assert (err_cnt === 16'(cur.xc)) else begin
        n_bad++;
        $error("FAIL %s err_cnt: observed %0d expected %0d", cur.tag, err_cnt, cur.xc);
      end
      n_cmp++;
      assert (locked2 === cur.xl && err2 === cur.xe) else begin
        n_bad++;
        $error("FAIL %s sat_flags: observed %0b%0b expected %0b%0b", cur.tag, locked2, err2, cur.xl, cur.xe);
      end
      n_cmp++;
      assert (err_cnt2 === xc2) else begin
        n_bad++;
        $error("FAIL %s sat_err_cnt: observed %0d expected %0d", cur.tag, err_cnt2, xc2);
      end
    end
  end

  task automatic cyc(input logic e, input logic d, input logic c, input logic r,
                     input logic xe, input string tag);
    @(negedge clk);
    en = e; din_bit = d; clr_cnt = c; rst = r;
    sb.push_back('{e_locked, xe, e_cnt, tag});
  endtask

  task automatic gen_bit(output logic b);
    b = g[20] ^ g[24] ^ g[25] ^ g[26];
    g = {g[25:1], b};
  endtask

  task automatic good(input logic c, input string tag);
    logic b;
    gen_bit(b);
    if (e_locked) sl++;
    else if (acq) begin
      vc++;
      if (vc >= 34) begin
        e_locked = 1'b1;
        acq = 1'b0;
        sl = 0;
      end
    end
    if (c) e_cnt = 0;
    cyc(1'b1, b, c, 1'b0, 1'b0, tag);
  endtask

  task automatic clean(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) good(1'b0, tag);
  endtask

  task automatic bad(input logic c, input logic lose, input string tag);
    logic b;
    gen_bit(b);
    sl++;
    e_cnt = c ? 1 : e_cnt + 1;
    if (lose) begin
      e_locked = 1'b0;
      acq = 1'b1;
      vc = 0;
    end
    cyc(1'b1, ~b, c, 1'b0, 1'b1, tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input logic d, input string tag);
    e_locked = 1'b0;
    e_cnt = 0;
    acq = 1'b1;
    vc = 0;
    cyc(1'b1, d, 1'b0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    int unsigned nv;

    do_reset(1'b0, "reset");
    do_reset(1'b1, "reset");

    // clean stream from the seed: lock exactly after 26+8 valid bits
    g = 26'h000001A;
    clean(34, "t1_acquire");
    clean(20, "t1_run");

    // single inverted bit while locked
    bad(1'b0, 1'b0, "t2_single");
    clean(30, "t2_after");

    // start a fresh window, then four errors inside it
    good(1'b1, "t3_clr");
    if (sl % 256 != 0) clean(256 - sl % 256, "t3_pad");
    repeat (3) begin
      bad(1'b0, 1'b0, "t3_err");
      clean(9, "t3_gap");
    end
    bad(1'b0, 1'b1, "t3_loss");
    clean(34, "t3_relock");
    clean(10, "t3_run");

    // build err_cnt=3 while locked, then reset over an errored bit
    good(1'b1, "t6_clr");
    repeat (3) begin
      bad(1'b0, 1'b0, "t6_err");
      clean(5, "t6_gap");
    end
    do_reset(1'b1, "t6_rst");
    idle("t6_idle");

    // all-zero input never locks; a clean stream afterwards does
    repeat (520) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t4_zero");
    clean(34, "t4_lock");
    clean(5, "t4_run");

    // clean stream with en gaps, then clear coinciding with a mismatch
    do_reset(1'b0, "t5_rst");
    nv = 0;
    while (nv < 60) begin
      if ($urandom_range(0, 2) == 0) idle("t5_idle");
      else begin
        good(1'b0, "t5_rand");
        nv++;
      end
    end
    bad(1'b0, 1'b0, "t5_err");
    clean(3, "t5_gap");
    bad(1'b1, 1'b0, "t5_clr_err");
    clean(3, "t5_run");
    idle("t5_end");

    repeat (3) @(negedge clk);
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL drain: observed %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
